// File: rtl/struct_fifo.sv
// -----------------------------------------------------------------------------
// struct_fifo
//
// Purpose:
//   Synchronous FIFO that stores a packed nested record
//   rec_t = {g:{a,b}, h[H_W-1:0]}. The record is W = H_W+2 bits wide and g.a
//   is its MSB. A record pushed into an empty FIFO appears on out_data one
//   cycle after the edge that wrote it. While no valid entry is held,
//   out_data shows IDLE_REC.
//
// Parameters:
//   DEPTH    - number of entries; a power of two in 2..64
//   H_W      - width of field h, 1..16
//   IDLE_REC - record shown on out_data while out_valid is low
//
// Ports:
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      write request
//   in_ready   out  1      space available (not full)
//   in_data    in   W      record to write
//   out_valid  out  1      head record valid
//   out_ready  in   1      consumer accepts the head record
//   out_data   out  W      head record, or IDLE_REC when not valid
//   out_a      out  1      out_data.g.a
//   out_b      out  1      out_data.g.b
//   out_h      out  H_W    out_data.h
//   count      out  clog2(DEPTH)+1  current occupancy
//
// Build option:
//   STRUCT_FIFO_BYPASS_EN - when defined, an empty FIFO forwards in_data to
//   out_data in the same cycle. If the consumer takes the record in that
//   cycle, it is never stored. When the macro is not defined, no
//   combinational path runs from in_* to out_*.
// -----------------------------------------------------------------------------
module struct_fifo #(
    parameter int                 DEPTH    = 4,
    parameter int                 H_W      = 3,
    parameter logic [H_W+1:0]     IDLE_REC = {1'b1, 1'b0, {H_W{1'b1}}}
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [H_W+1:0]             in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [H_W+1:0]             out_data,
    output logic                       out_a,
    output logic                       out_b,
    output logic [H_W-1:0]             out_h,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        struct packed {
            logic a;
            logic b;
        } g;
        logic [H_W-1:0] h;
    } rec_t;

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic empty_s;
    logic full_s;
    logic byp_s;
    logic push_s;
    logic pop_s;
    logic store_s;
    logic mem_pop_s;
    rec_t head_s;

    // Occupancy flags come only from registered state.
    always_comb begin
        empty_s = (count_q == {CNT_W{1'b0}});
        full_s  = (count_q == DEPTH_C);
    end

    // Bypass qualifier: active only for an empty FIFO with a pending write.
    always_comb begin
`ifdef STRUCT_FIFO_BYPASS_EN
        byp_s = empty_s & in_valid;
`else
        byp_s = 1'b0;
`endif
    end

    // Handshakes. A bypassed record that is consumed in the same cycle is
    // not written, so the count stays at zero.
    always_comb begin
        push_s    = in_valid & ~full_s;
        pop_s     = out_valid & out_ready;
        store_s   = push_s & ~(byp_s & out_ready);
        mem_pop_s = pop_s & ~empty_s;
    end

    // Head record selection: stored head, forwarded input, or the idle record.
    always_comb begin
        head_s = rec_t'(IDLE_REC);
        if (!empty_s) begin
            head_s = mem_q[rd_ptr_q];
        end else if (byp_s) begin
            head_s = rec_t'(in_data);
        end else begin
            head_s = rec_t'(IDLE_REC);
        end
    end

    // Output drive. The field outputs are plain slices of the head record.
    always_comb begin
        in_ready  = ~full_s;
        out_valid = ~empty_s | byp_s;
        out_data  = head_s;
        out_a     = head_s.g.a;
        out_b     = head_s.g.b;
        out_h     = head_s.h;
        count     = count_q;
    end

    // Next-state for pointers and occupancy. DEPTH is a power of two, so the
    // pointers wrap from DEPTH-1 to 0 by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (mem_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({store_s, mem_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register. Reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array. It has no reset: cleared pointers make old contents
    // unreachable.
    always_ff @(posedge clk) begin
        if (store_s && !rst) begin
            mem_q[wr_ptr_q] <= rec_t'(in_data);
        end
    end

endmodule

// File: tb/tb_struct_fifo.sv
module tb_struct_fifo;

    localparam int DEPTH = 4;
    localparam int H_W   = 3;
    localparam int W     = H_W + 2;
    localparam logic [W-1:0] IDLE = 5'b10111;
`ifdef STRUCT_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic           out_a;
    logic           out_b;
    logic [H_W-1:0] out_h;
    logic [$clog2(DEPTH):0] count;

    int n_total = 0;
    int n_pass  = 0;
    bit mon_en  = 1'b0;
    bit acc_pending = 1'b0;
    logic [W-1:0] acc_data;
    logic [W-1:0] sb_q[$];

    struct_fifo #(.DEPTH(DEPTH), .H_W(H_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_a(out_a), .out_b(out_b), .out_h(out_h), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Set the inputs for the next edge and decide, from the reference queue
    // alone, whether the write will be accepted into storage.
    task automatic set_in(input bit v, input logic [W-1:0] d, input bit r, input bit rs);
        int sz;
        sz = sb_q.size();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        rst       = rs;
        acc_pending = v && !rs && (sz < DEPTH) && !(BYP && sz == 0 && r);
        acc_data    = d;
    endtask

    // Advance one edge and update the reference contents.
    task automatic tick();
        @(posedge clk);
        if (rst) sb_q.delete();
        else if (acc_pending) sb_q.push_back(acc_data);
        acc_pending = 1'b0;
        #1;
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        set_in(v, d, r, 1'b0);
        tick();
    endtask

    // Monitor: checks status against the reference and pops the scoreboard
    // whenever the DUT presents a record that is being consumed.
    always @(negedge clk) begin
        if (mon_en) begin
            int sz;
            logic [W-1:0] exp_d;
            bit exp_v;
            sz = sb_q.size();
            exp_v = (sz != 0) || (BYP && in_valid);
            check("count", 32'(count), 32'(sz));
            check("in_ready", 32'(in_ready), 32'(sz != DEPTH));
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (sz != 0) exp_d = sb_q[0];
            else if (exp_v) exp_d = in_data;
            else exp_d = IDLE;
            check("out_data", 32'(out_data), 32'(exp_d));
            check("out_a", 32'(out_a), 32'(exp_d[W-1]));
            check("out_b", 32'(out_b), 32'(exp_d[W-2]));
            check("out_h", 32'(out_h), 32'(exp_d[H_W-1:0]));
            if (out_valid && out_ready && !rst && sz != 0) void'(sb_q.pop_front());
        end
    end

    initial begin
        // Reset state
        set_in(1'b0, '0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        mon_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_data", 32'(out_data), 32'(5'b10111));
        check("rst_out_h", 32'(out_h), 32'(3'b111));

        // Ordered push of three records, then drain
        step(1'b1, 5'b01010, 1'b0);
        check("cnt1", 32'(count), 32'd1);
        step(1'b1, 5'b11001, 1'b0);
        check("cnt2", 32'(count), 32'd2);
        step(1'b1, 5'b00100, 1'b0);
        check("cnt3", 32'(count), 32'd3);
        check("head_h", 32'(out_h), 32'(3'b010));
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("idle_after_drain", 32'(out_data), 32'(IDLE));

        // Fill, then hold a blocked write; pop once while the write is still
        // offered, then drain with the write withdrawn
        for (int i = 0; i < DEPTH; i++) step(1'b1, W'(5'd3 + i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'b11111, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);
        step(1'b1, 5'b11111, 1'b1);
        check("pop_when_full_cnt", 32'(count), 32'd3);
        check("in_ready_rises", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

        // Two held, then ten cycles of simultaneous push and pop
        step(1'b1, 5'b00001, 1'b0);
        step(1'b1, 5'b00010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, W'(5'd10 + i), 1'b1);
            check("steady_count", 32'(count), 32'd2);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Reset with three held while a write is in flight
        for (int i = 0; i < 3; i++) step(1'b1, W'(5'd20 + i), 1'b0);
        set_in(1'b1, 5'b01111, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        check("rst_flush_count", 32'(count), 32'd0);
        check("rst_flush_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // Write into an empty FIFO with the consumer ready
        set_in(1'b1, 5'b10001, 1'b1, 1'b0);
        #1;
        check("byp_valid_same", 32'(out_valid), 32'(BYP));
        if (BYP) check("byp_data_same", 32'(out_data), 32'(5'b10001));
        tick();
        set_in(1'b0, '0, 1'b1, 1'b0);
        #1;
        check("byp_count", 32'(count), 32'(BYP ? 0 : 1));
        check("byp_valid_next", 32'(out_valid), 32'(!BYP));
        tick();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            set_in(1'b1 && ($urandom_range(0, 2) != 0), W'($urandom),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
            tick();
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 2; i++) tick();
        check("final_empty", 32'(sb_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/struct_fifo.md
STRUCT_FIFO -- requirements
Module: struct_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; power of two, 2..64.
REQ-002 SHALL have parameter H_W, default 3: width of record field h, 1..16.
REQ-003 SHALL have parameter IDLE_REC, default {g:{a:1'b1,b:1'b0},h:all-ones}: record presented on out_data when no valid entry is held.
REQ-004 SHALL define record type rec_t as a packed nested struct {g:{a,b}, h[H_W-1:0]}, width W=H_W+2, with g.a at the MSB.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1: write request.
REQ-008 SHALL have port in_ready, output, 1: space available.
REQ-009 SHALL have port in_data, input, W: record to write.
REQ-010 SHALL have port out_valid, output, 1: head record valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the head record.
REQ-012 SHALL have port out_data, output, W: head record.
REQ-013 SHALL have port out_a, output, 1: equals out_data.g.a.
REQ-014 SHALL have port out_b, output, 1: equals out_data.g.b.
REQ-015 SHALL have port out_h, output, H_W: equals out_data.h.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1: current occupancy.

Function
REQ-017 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be (count != DEPTH), registered-state derived; it SHALL NOT depend on out_ready.
REQ-019 out_valid SHALL be (count != 0), except as modified by REQ-032.
REQ-020 Order SHALL be strictly FIFO; each accepted record SHALL be popped exactly once and unmodified.
REQ-021 Write-to-read latency SHALL be 1 cycle: a record pushed into an empty FIFO at edge N SHALL appear on out_data, with out_valid=1, after edge N.
REQ-022 When out_valid=0, out_data SHALL equal IDLE_REC.
REQ-023 out_a, out_b and out_h SHALL be combinational slices of out_data.
REQ-024 Read and write pointers SHALL be clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-025 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
REQ-026 When full, in_valid SHALL be ignored; a simultaneous pop SHALL still occur, and in_ready SHALL rise on the next cycle.
REQ-027 When empty, out_ready SHALL be ignored.
REQ-028 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.

Reset
REQ-029 On rst=1 at a clock edge, pointers and count SHALL clear to 0; then out_valid=0, in_ready=1 and out_data=IDLE_REC.
REQ-030 Reset SHALL take priority over a simultaneous push or pop, and all in-flight contents SHALL be discarded.
REQ-031 Storage array contents SHALL NOT require reset.

Configuration
REQ-032 Macro STRUCT_FIFO_BYPASS_EN defined: when count=0 and in_valid=1, out_valid SHALL be 1 and out_data SHALL equal in_data in the same cycle.
  - If out_ready=1 in that cycle, the record SHALL be consumed without being stored, and count SHALL stay 0.
  - If out_ready=0, the record SHALL be stored normally.
REQ-033 Macro STRUCT_FIFO_BYPASS_EN undefined: no combinational path from in_* to out_*; latency per REQ-021.

Verification
REQ-034 Reset, defaults -> out_valid=0, in_ready=1, count=0, out_data=5'b10111, out_a=1, out_b=0, out_h=3'b111.
REQ-035 Push 5'b01010, 5'b11001, 5'b00100 with out_ready=0, then pop all -> count 1,2,3; pops return the same order; out_h returns 3'b010, 3'b001, 3'b100; IDLE_REC is shown after the last pop.
REQ-036 Fill to DEPTH=4, then hold in_valid=1 with record 5'b11111 -> in_ready=0, count stays 4, 5'b11111 is never popped.
REQ-037 count=2 with continuous push+pop for 10 cycles -> count stays 2 and pointers wrap; the output sequence equals the input sequence delayed by 2 records.
REQ-038 Assert rst with count=3 while pushing -> next cycle count=0 and out_valid=0; the in-flight record is not later popped.
REQ-039 With STRUCT_FIFO_BYPASS_EN: empty FIFO, in_valid=1 with 5'b10001, out_ready=1 -> out_data=5'b10001 in the same cycle and count stays 0; without the macro, out_valid=0 that cycle and 1 the next.
